tinyrv_spi_mem_ctrl: RTL

SPI-mode-0 serial SRAM controller for the tinyrv core. It converts single load/store requests (byte, half or word) from the core's memory stage or fetch unit into SPI READ (0x03) and WRITE (0x02) transactions on the TT pins. It is parametrised in address width and dummy cycles so the same block serves different serial RAM/flash parts. It sits between the core and the ui_in/uo_out/uio pin mux in the top module.

---
 rtl/tinyrv_spi_mem_ctrl.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/tinyrv_spi_mem_ctrl.sv
// tinyrv_spi_mem_ctrl: SPI mode-0 serial SRAM controller for the tinyrv core.
// Turns single byte/half/word load/store requests into SPI READ (0x03) and
// WRITE (0x02) transactions. SCK runs at clk/2; every bit is a two-cycle
// phase pair (A: sck=0 and mosi driven, B: sck=1, miso sampled at its end).
// Optional feature: define TINYRV_SPI_MODE_INIT_EN to send a WRMR 0x01,0x40
// (sequential mode) sequence after reset before the first request is taken.
module tinyrv_spi_mem_ctrl #(
  parameter int unsigned ADDR_W       = 24,
  parameter int unsigned DUMMY_CYCLES = 0,
  parameter int unsigned CS_IDLE      = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              spi_cs_n,
  output logic              spi_sck,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_DONE,
    ST_BOOT,
    ST_INIT
  } state_t;

`ifdef TINYRV_SPI_MODE_INIT_EN
  // BOOT keeps cs_n high while reset is asserted; INIT starts on the first edge after release.
  localparam state_t RESET_STATE = ST_BOOT;
`else
  localparam state_t RESET_STATE = ST_IDLE;
`endif

  localparam logic [7:0]  CMD_READ  = 8'h03;
  localparam logic [7:0]  CMD_WRITE = 8'h02;
  localparam logic [15:0] WRMR_SEQ  = 16'h0140;

  state_t state, next_state;

  // Bit engine
  logic        phase;       // 0 = phase A (sck low), 1 = phase B (sck high)
  logic [5:0]  bit_cnt;     // bits remaining in the current state
  logic [31:0] tx_sh;       // outgoing bits, MSB is on the wire
  logic [31:0] rx_sh;       // incoming bits, first received ends up highest
  logic [15:0] idle_cnt;    // cs_n-high cycles still owed before the next request

  // Request latched at handshake
  logic              we_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  // Combinational helpers
  logic        shifting;
  logic        last_bit;
  logic        handshake;
  logic        rd_sample;
  logic [5:0]  data_bits;
  logic [5:0]  load_cnt;
  logic [31:0] load_val;
  logic [31:0] wswap;
  logic [31:0] rx_next;
  logic [31:0] rd_fmt;

  assign shifting  = (state == ST_CMD) || (state == ST_ADDR) || (state == ST_DUMMY) ||
                     (state == ST_DATA) || (state == ST_INIT);
  assign last_bit  = shifting && phase && (bit_cnt == 6'd1);
  assign req_ready = (state == ST_IDLE) && (idle_cnt == '0);
  assign handshake = req_valid && req_ready;
  assign rd_sample = (state == ST_DATA) && !we_q && phase;

  // Byte k goes out k-th, so byte 0 is placed at the top of the shift register.
  assign wswap   = {wdata_q[7:0], wdata_q[15:8], wdata_q[23:16], wdata_q[31:24]};
  assign rx_next = {rx_sh[30:0], spi_miso};

  // Outputs are decoded from state so reset forces cs_n high immediately.
  assign spi_cs_n   = ~shifting;
  assign spi_sck    = shifting & phase;
  assign spi_mosi   = shifting & tx_sh[31];
  assign resp_valid = (state == ST_DONE);

  // Number of data bits for the latched access size (reserved size acts as word).
  always_comb begin
    data_bits = 6'd32;
    case (size_q)
      2'd0:    data_bits = 6'd8;
      2'd1:    data_bits = 6'd16;
      default: data_bits = 6'd32;
    endcase
  end

  // Reorder received bytes into little-endian lanes, zero-filling unused lanes.
  always_comb begin
    rd_fmt = '0;
    case (size_q)
      2'd0:    rd_fmt = {24'h0, rx_next[7:0]};
      2'd1:    rd_fmt = {16'h0, rx_next[7:0], rx_next[15:8]};
      default: rd_fmt = {rx_next[7:0], rx_next[15:8], rx_next[23:16], rx_next[31:24]};
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RESET_STATE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: each shifting state advances after the phase B of its last bit.
  always_comb begin
    next_state = state;
    case (state)
      ST_BOOT:  next_state = ST_INIT;
      ST_INIT:  if (last_bit) next_state = ST_IDLE;
      ST_IDLE:  if (handshake) next_state = ST_CMD;
      ST_CMD:   if (last_bit) next_state = ST_ADDR;
      ST_ADDR: begin
        if (last_bit) begin
          if (!we_q && (DUMMY_CYCLES != 0)) next_state = ST_DUMMY;
          else                              next_state = ST_DATA;
        end
      end
      ST_DUMMY: if (last_bit) next_state = ST_DATA;
      ST_DATA:  if (last_bit) next_state = ST_DONE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Bit count and shift contents to load when entering a shifting state.
  // CMD is only entered straight from the handshake, so it decodes req_we directly.
  always_comb begin
    load_cnt = '0;
    load_val = '0;
    case (next_state)
      ST_INIT: begin
        load_cnt = 6'd16;
        load_val = {WRMR_SEQ, 16'h0};
      end
      ST_CMD: begin
        load_cnt = 6'd8;
        load_val = {(req_we ? CMD_WRITE : CMD_READ), 24'h0};
      end
      ST_ADDR: begin
        load_cnt = 6'(ADDR_W);
        load_val = 32'(addr_q) << (32 - ADDR_W);
      end
      ST_DUMMY: begin
        load_cnt = 6'(DUMMY_CYCLES);
        load_val = '0;
      end
      ST_DATA: begin
        load_cnt = data_bits;
        load_val = we_q ? wswap : '0;
      end
      default: begin
        load_cnt = '0;
        load_val = '0;
      end
    endcase
  end

  // Bit engine: reload on every state change, otherwise toggle phase and shift after phase B.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= 1'b0;
      bit_cnt <= '0;
      tx_sh   <= '0;
    end else if (next_state != state) begin
      phase   <= 1'b0;
      bit_cnt <= load_cnt;
      tx_sh   <= load_val;
    end else if (shifting) begin
      phase <= ~phase;
      if (phase) begin
        tx_sh   <= tx_sh << 1;
        bit_cnt <= bit_cnt - 6'd1;
      end
    end
  end

  // Capture the request at handshake; inputs are ignored afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (handshake) begin
      we_q    <= req_we;
      size_q  <= req_size;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Receive shifter: samples miso at the edge that ends phase B of each read data bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sh <= '0;
    end else if (handshake) begin
      rx_sh <= '0;
    end else if (rd_sample) begin
      rx_sh <= rx_next;
    end
  end

  // Read result is published together with the final sample so it is valid during DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_rdata <= '0;
    end else if (rd_sample && last_bit) begin
      resp_rdata <= rd_fmt;
    end
  end

  // Idle spacing: DONE is the first cs_n-high cycle, so CS_IDLE-1 more are owed after it;
  // after INIT nothing has been spent yet, so the full CS_IDLE is owed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if ((next_state == ST_DONE) && (state != ST_DONE)) begin
      idle_cnt <= 16'(CS_IDLE - 1);
    end else if ((state == ST_INIT) && last_bit) begin
      idle_cnt <= 16'(CS_IDLE);
    end else if ((state == ST_IDLE) && (idle_cnt != '0)) begin
      idle_cnt <= idle_cnt - 16'd1;
    end
  end

endmodule
